// File: rtl/ram_port_arbiter.sv
// Shares one simple dual-port RAM between two masters with independent round-robin write/read arbitration.
// Define RAM_PORT_ARBITER_INIT_EN to scrub every location with INIT_VALUE after reset.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  logic                  arb_en;
  logic                  wr_c0, wr_c1, rd_c0, rd_c1;
  logic                  wg0, wg1, rg0, rg1;
  // Last-grantee pointers: 1 means m1 was served last, so m0 wins the next tie.
  logic                  wr_last_q, rd_last_q;
  logic                  m0_rvalid_q, m1_rvalid_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

`ifdef RAM_PORT_ARBITER_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  sweep;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_RUN;
    end
  end

  assign busy   = (state_q == ST_INIT);
  assign sweep  = busy && !rst;
  assign arb_en = (state_q == ST_RUN) && !rst;
`else
  logic unused_init;
  assign unused_init = ^INIT_VALUE;
  assign busy        = 1'b0;
  assign arb_en      = !rst;
`endif

  always_comb begin
    wr_c0 = m0_req && m0_we;
    wr_c1 = m1_req && m1_we;
    rd_c0 = m0_req && !m0_we;
    rd_c1 = m1_req && !m1_we;
    wg0   = arb_en && wr_c0 && (!wr_c1 || wr_last_q);
    wg1   = arb_en && wr_c1 && (!wr_c0 || !wr_last_q);
    rg0   = arb_en && rd_c0 && (!rd_c1 || rd_last_q);
    rg1   = arb_en && rd_c1 && (!rd_c0 || !rd_last_q);

    ram_we         = 1'b0;
    ram_write_addr = m0_addr;
    ram_data       = m0_wdata;
`ifdef RAM_PORT_ARBITER_INIT_EN
    if (sweep) begin
      ram_we         = 1'b1;
      ram_write_addr = cnt_q;
      ram_data       = INIT_VALUE;
    end else
`endif
    if (wg1) begin
      ram_we         = 1'b1;
      ram_write_addr = m1_addr;
      ram_data       = m1_wdata;
    end else if (wg0) begin
      ram_we = 1'b1;
    end

    // The RAM samples its read address on the edge, so the grant drives it directly.
    if (rg0)      ram_read_addr = m0_addr;
    else if (rg1) ram_read_addr = m1_addr;
    else          ram_read_addr = rd_addr_q;
  end

  assign m0_gnt    = wg0 || rg0;
  assign m1_gnt    = wg1 || rg1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = ram_q;
  assign m1_rdata  = ram_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_last_q   <= 1'b1;
      rd_last_q   <= 1'b1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      if (wg0 || wg1) wr_last_q <= wg1;
      if (rg0 || rg1) rd_last_q <= rg1;
      m0_rvalid_q <= rg0;
      m1_rvalid_q <= rg1;
    end
  end

  always_ff @(posedge clk) begin
    if (rg0 || rg1) rd_addr_q <= ram_read_addr;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, shadow memory and per-master read-data scoreboards.
module tb_ram_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] INITV = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, ram_we;
  logic [DW-1:0] m0_rdata, m1_rdata, ram_data, ram_q;
  logic [AW-1:0] ram_write_addr, ram_read_addr;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INITV)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .busy(busy), .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_data(ram_data),
    .ram_read_addr(ram_read_addr), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Simple dual-port RAM with registered read; NBA ordering gives read-before-write.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] q0_d[$], q1_d[$];
  int            q0_t[$], q1_t[$];
  logic [DW-1:0] mon_d;
  int            mon_t;

  // Scoreboard: each expected read is due exactly one cycle after its grant.
  always @(negedge clk) begin
    if (q0_t.size() != 0 && !m0_rvalid && q0_t[0] + 1 <= cyc) begin
      n_vec++; n_err++;
      $display("FAIL m0_rvalid_missing: got 0 want 1 at cycle %0d", cyc);
      mon_t = q0_t.pop_front(); mon_d = q0_d.pop_front();
    end
    if (m0_rvalid) begin
      n_vec++;
      if (q0_t.size() == 0) begin
        n_err++;
        $display("FAIL m0_rvalid_spurious: got 1 want 0 at cycle %0d", cyc);
      end else begin
        mon_t = q0_t.pop_front(); mon_d = q0_d.pop_front();
        if (mon_t + 1 != cyc || m0_rdata !== mon_d) begin
          n_err++;
          $display("FAIL m0_rdata: got %h at cycle %0d want %h at cycle %0d", m0_rdata, cyc, mon_d, mon_t + 1);
        end
      end
    end
    if (q1_t.size() != 0 && !m1_rvalid && q1_t[0] + 1 <= cyc) begin
      n_vec++; n_err++;
      $display("FAIL m1_rvalid_missing: got 0 want 1 at cycle %0d", cyc);
      mon_t = q1_t.pop_front(); mon_d = q1_d.pop_front();
    end
    if (m1_rvalid) begin
      n_vec++;
      if (q1_t.size() == 0) begin
        n_err++;
        $display("FAIL m1_rvalid_spurious: got 1 want 0 at cycle %0d", cyc);
      end else begin
        mon_t = q1_t.pop_front(); mon_d = q1_d.pop_front();
        if (mon_t + 1 != cyc || m1_rdata !== mon_d) begin
          n_err++;
          $display("FAIL m1_rdata: got %h at cycle %0d want %h at cycle %0d", m1_rdata, cyc, mon_d, mon_t + 1);
        end
      end
    end
  end

  // Drive one cycle of inputs just after the edge; return mid-cycle for checks.
  task automatic drive(input logic r,
                       input logic rq0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic rq1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    @(posedge clk); #1;
    rst = r;
    m0_req = rq0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = rq1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic exp_rd(input int m, input logic [AW-1:0] a);
    if (m == 0) begin q0_d.push_back(shadow[a]); q0_t.push_back(cyc); end
    else        begin q1_d.push_back(shadow[a]); q1_t.push_back(cyc); end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 6'd1, 8'hEE, 1'b1, 1'b0, 6'd2, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 6'd1, 8'hEE, 1'b1, 1'b0, 6'd2, 8'h00);
    n_vec++;
    if ({m0_gnt, m1_gnt, ram_we, m0_rvalid, m1_rvalid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got gnt=%b%b we=%b rv=%b%b want all 0", m0_gnt, m1_gnt, ram_we, m0_rvalid, m1_rvalid);
    end
`ifdef RAM_PORT_ARBITER_INIT_EN
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 1'b1, 6'd1, 8'hEE, 1'b1, 1'b0, 6'd2, 8'h00);
      n_vec++;
      if (busy !== 1'b1 || ram_we !== 1'b1 || ram_write_addr !== AW'(i) || ram_data !== INITV
          || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL sweep_%0d: got busy=%b we=%b addr=%0d data=%h gnt=%b%b want 1 1 %0d a5 00",
                 i, busy, ram_we, ram_write_addr, ram_data, m0_gnt, m1_gnt, i);
      end
      shadow[i] = INITV;
    end
    idle();
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL sweep_end_busy: got %b want 0", busy); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0);
      n_vec++;
      if (m1_gnt !== 1'b1) begin n_err++; $display("FAIL readall_gnt_%0d: got %b want 1", i, m1_gnt); end
      exp_rd(1, AW'(i));
    end
`else
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 6'd0, 8'h5E);
    n_vec++;
    if (m1_gnt !== 1'b1 || ram_we !== 1'b1 || ram_write_addr !== 6'd0 || ram_data !== 8'h5E) begin
      n_err++;
      $display("FAIL first_grant: got gnt=%b we=%b addr=%0d data=%h want 1 1 0 5e", m1_gnt, ram_we, ram_write_addr, ram_data);
    end
    shadow[0] = 8'h5E;
`endif
    idle();
  endtask

  task automatic test_write_contention();
    drive(1'b0, 1'b1, 1'b1, 6'd3, 8'h11, 1'b1, 1'b1, 6'd4, 8'h22);
    n_vec++;
    if ({m0_gnt, m1_gnt} !== 2'b10 || ram_we !== 1'b1 || ram_write_addr !== 6'd3 || ram_data !== 8'h11) begin
      n_err++;
      $display("FAIL wr_cont_1: got gnt=%b%b we=%b addr=%0d data=%h want 10 1 3 11", m0_gnt, m1_gnt, ram_we, ram_write_addr, ram_data);
    end
    shadow[3] = 8'h11;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 6'd4, 8'h22);
    n_vec++;
    if ({m0_gnt, m1_gnt} !== 2'b01 || ram_we !== 1'b1 || ram_write_addr !== 6'd4 || ram_data !== 8'h22) begin
      n_err++;
      $display("FAIL wr_cont_2: got gnt=%b%b we=%b addr=%0d data=%h want 01 1 4 22", m0_gnt, m1_gnt, ram_we, ram_write_addr, ram_data);
    end
    shadow[4] = 8'h22;
    drive(1'b0, 1'b1, 1'b0, 6'd3, '0, 1'b0, 1'b0, '0, '0);
    exp_rd(0, 6'd3);
    drive(1'b0, 1'b1, 1'b0, 6'd4, '0, 1'b0, 1'b0, '0, '0);
    exp_rd(0, 6'd4);
    idle();
  endtask

  task automatic test_parallel_ports();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 6'd7, 8'h77);
    shadow[7] = 8'h77;
    drive(1'b0, 1'b1, 1'b1, 6'd5, 8'h3C, 1'b1, 1'b0, 6'd7, '0);
    n_vec++;
    if ({m0_gnt, m1_gnt} !== 2'b11 || ram_we !== 1'b1 || ram_write_addr !== 6'd5 || ram_read_addr !== 6'd7) begin
      n_err++;
      $display("FAIL parallel: got gnt=%b%b we=%b waddr=%0d raddr=%0d want 11 1 5 7", m0_gnt, m1_gnt, ram_we, ram_write_addr, ram_read_addr);
    end
    exp_rd(1, 6'd7);
    shadow[5] = 8'h3C;
    idle();
  endtask

  task automatic test_collision();
    drive(1'b0, 1'b1, 1'b1, 6'd9, 8'h01, 1'b0, 1'b0, '0, '0);
    shadow[9] = 8'h01;
    drive(1'b0, 1'b1, 1'b1, 6'd9, 8'h02, 1'b1, 1'b0, 6'd9, '0);
    n_vec++;
    if ({m0_gnt, m1_gnt} !== 2'b11) begin
      n_err++; $display("FAIL collision_gnt: got %b%b want 11", m0_gnt, m1_gnt);
    end
    exp_rd(1, 6'd9);
    shadow[9] = 8'h02;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd9, '0);
    exp_rd(1, 6'd9);
    idle();
  endtask

  task automatic test_read_round_robin();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 6'd3, '0, 1'b1, 1'b0, 6'd4, '0);
      n_vec++;
      if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL rd_rr_%0d: got gnt=%b%b want %s", i, m0_gnt, m1_gnt, (i % 2 == 0) ? "10" : "01");
      end
      if (i % 2 == 0) exp_rd(0, 6'd3); else exp_rd(1, 6'd4);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    addrs[0] = 6'd5; addrs[1] = 6'd7; addrs[2] = 6'd9;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, addrs[i], '0, 1'b0, 1'b0, '0, '0);
      n_vec++;
      if (m0_gnt !== 1'b1 || (i > 0 && m0_rvalid !== 1'b1)) begin
        n_err++; $display("FAIL b2b_%0d: got gnt=%b rvalid=%b want 1 1", i, m0_gnt, m0_rvalid);
      end
      exp_rd(0, addrs[i]);
    end
    idle();
    n_vec++;
    if (m0_rvalid !== 1'b1) begin n_err++; $display("FAIL b2b_tail: got rvalid=%b want 1", m0_rvalid); end
  endtask

  task automatic test_reset_midop();
`ifdef RAM_PORT_ARBITER_INIT_EN
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 20; i++) idle();
`endif
    drive(1'b1, 1'b1, 1'b0, 6'd3, '0, 1'b1, 1'b0, 6'd4, '0);
    n_vec++;
    if ({m0_gnt, m1_gnt, ram_we} !== 3'b000) begin
      n_err++; $display("FAIL midop_rst: got gnt=%b%b we=%b want 000", m0_gnt, m1_gnt, ram_we);
    end
    idle();
    n_vec++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      n_err++; $display("FAIL midop_rvalid: got %b%b want 00", m0_rvalid, m1_rvalid);
    end
`ifdef RAM_PORT_ARBITER_INIT_EN
    n_vec++;
    if (busy !== 1'b1 || ram_we !== 1'b1 || ram_write_addr !== 6'd0) begin
      n_err++; $display("FAIL midop_restart: got busy=%b we=%b addr=%0d want 1 1 0", busy, ram_we, ram_write_addr);
    end
    for (int i = 0; i < DEPTH; i++) shadow[i] = INITV;
    for (int i = 1; i < DEPTH; i++) idle();
`endif
    drive(1'b0, 1'b1, 1'b0, 6'd3, '0, 1'b1, 1'b0, 6'd4, '0);
    n_vec++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      n_err++; $display("FAIL midop_ptr: got gnt=%b%b want 10", m0_gnt, m1_gnt);
    end
    exp_rd(0, 6'd3);
    idle();
    idle();
  endtask

  initial begin
    test_reset();
    test_write_contention();
    test_parallel_ports();
    test_collision();
    test_read_round_robin();
    test_back_to_back();
    test_reset_midop();
    n_vec++;
    if (q0_t.size() != 0 || q1_t.size() != 0) begin
      n_err++; $display("FAIL pending_reads: got %0d/%0d outstanding want 0/0", q0_t.size(), q1_t.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
